// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-sequencer types and defaults.
// State encoding plus reset-vector / PC-step defaults.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_EXEC,
    S_HALT
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int          PC_STEP_DEF      = 4;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register with load enable.
// Resets to RESET_VECTOR.
module pc_reg
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // PC holds unless load is asserted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= RESET_VECTOR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetch, issue, wait for retire.
// Chooses the next PC from halt / branch / sequential step.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          PC_STEP      = PC_STEP_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        misalign_err
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         pc_load;
  logic [31:0]  pc_d;
  logic         instr_load;
  logic         mis_set;
  logic         mis_clr;

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clock(clock),
    .reset(reset),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc_out)
  );

  // State, fetched word and sticky misalign flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      instr        <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_load) begin
        instr <= imem_rdata;
      end
      if (mis_clr) begin
        misalign_err <= 1'b0;
      end else if (mis_set) begin
        misalign_err <= 1'b1;
      end
    end
  end

  // Next state and next-PC selection
  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    pc_d       = pc_out;
    instr_load = 1'b0;
    mis_set    = 1'b0;
    mis_clr    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_load = 1'b1;
          pc_d    = RESET_VECTOR;
          mis_clr = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_load = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_EXEC;
      end
      S_WAIT_EXEC: begin
        if (exec_done) begin
          if (halt) begin
            state_d = S_HALT;
          end else if (branch_taken
                       && branch_target[1:0] != 2'b00) begin
            mis_set = 1'b1;
            state_d = S_HALT;
          end else if (branch_taken) begin
            pc_load = 1'b1;
            pc_d    = branch_target;
            state_d = S_FETCH;
          end else begin
            pc_load = 1'b1;
            pc_d    = pc_out + 32'(PC_STEP);
            state_d = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded straight from state
  always_comb begin
    imem_req    = (state_q == S_FETCH);
    instr_valid = (state_q == S_ISSUE);
    busy        = (state_q == S_FETCH)
               || (state_q == S_ISSUE)
               || (state_q == S_WAIT_EXEC);
    imem_addr   = pc_out;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Hand-computed expectations checked with immediate assertions.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic [31:0] pc_out;
  logic        busy;
  logic        misalign_err;

  int checks;
  int passed;
  int fails;

  fetch_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt         (halt),
    .pc_out       (pc_out),
    .busy         (busy),
    .misalign_err (misalign_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ack a fetch; leaves the DUT in WAIT_EXEC
  task automatic do_fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    step();
  endtask

  task automatic retire(input logic br,
                        input logic [31:0] tgt,
                        input logic hlt);
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hlt;
    step();
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    halt          = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    fails  = 0;
    reset         = 1'b0;
    start         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    halt          = 1'b0;

    step();
    step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ivalid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_mis", 32'(misalign_err), 32'h0);

    reset = 1'b1;
    imem_ack = 1'b1;
    step();
    step();
    imem_ack = 1'b0;
    chk("idle_req", 32'(imem_req), 32'h0);
    chk("idle_ack_ign", 32'(instr_valid), 32'h0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_req", 32'(imem_req), 32'h1);
    chk("start_addr", imem_addr, 32'h0);
    chk("start_busy", 32'(busy), 32'h1);

    step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    step();
    chk("wait_req", 32'(imem_req), 32'h1);
    chk("wait_addr", imem_addr, 32'h0);
    chk("spur_done_pc", pc_out, 32'h0);

    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("issue_valid", 32'(instr_valid), 32'h1);
    chk("issue_instr", instr, 32'hDEAD_BEEF);
    chk("issue_req", 32'(imem_req), 32'h0);
    step();
    chk("pulse_once", 32'(instr_valid), 32'h0);
    chk("instr_hold", instr, 32'hDEAD_BEEF);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("spur_start_req", 32'(imem_req), 32'h0);
    chk("spur_start_busy", 32'(busy), 32'h1);
    chk("spur_start_pc", pc_out, 32'h0);

    retire(1'b0, 32'h0, 1'b0);
    chk("seq_pc4", pc_out, 32'h4);
    chk("seq_req4", 32'(imem_req), 32'h1);
    do_fetch(32'h1111_1111);
    retire(1'b0, 32'h0, 1'b0);
    chk("seq_pc8", pc_out, 32'h8);
    do_fetch(32'h2222_2222);
    retire(1'b0, 32'h0, 1'b0);
    chk("seq_pc12", imem_addr, 32'hC);

    do_fetch(32'h3333_3333);
    chk("instr_3", instr, 32'h3333_3333);
    retire(1'b1, 32'h100, 1'b0);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_req", 32'(imem_req), 32'h1);

    do_fetch(32'h4444_4444);
    retire(1'b1, 32'h102, 1'b0);
    chk("mis_flag", 32'(misalign_err), 32'h1);
    chk("mis_pc", pc_out, 32'h100);
    chk("mis_busy", 32'(busy), 32'h0);
    chk("mis_req", 32'(imem_req), 32'h0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_pc", pc_out, 32'h0);
    chk("restart_mis", 32'(misalign_err), 32'h0);
    chk("restart_req", 32'(imem_req), 32'h1);

    do_fetch(32'h5555_5555);
    retire(1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("top_pc", pc_out, 32'hFFFF_FFFC);
    do_fetch(32'h6666_6666);
    retire(1'b0, 32'h0, 1'b0);
    chk("wrap_pc", pc_out, 32'h0);
    do_fetch(32'h7777_7777);
    retire(1'b0, 32'h0, 1'b0);
    chk("post_wrap_pc", pc_out, 32'h4);

    do_fetch(32'h8888_8888);
    retire(1'b1, 32'h200, 1'b1);
    chk("halt_pc", pc_out, 32'h4);
    chk("halt_busy", 32'(busy), 32'h0);
    chk("halt_mis", 32'(misalign_err), 32'h0);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("halt_ack_ign", 32'(instr_valid), 32'h0);
    chk("halt_instr", instr, 32'h8888_8888);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("halt_start_pc", pc_out, 32'h0);
    do_fetch(32'h9999_9999);
    retire(1'b1, 32'h40, 1'b0);
    chk("pre_rst_addr", imem_addr, 32'h40);
    step();

    reset = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_instr", instr, 32'h0);
    step();
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack   = 1'b0;
    chk("late_ack_valid", 32'(instr_valid), 32'h0);
    chk("late_ack_instr", instr, 32'h0);
    step();
    chk("stay_idle_req", 32'(imem_req), 32'h0);
    chk("stay_idle_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded by reset and by start.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning the sequential PC increment in bytes.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin fetching from RESET_VECTOR.
REQ-006 SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-007 SHALL have port imem_addr, output, 32 bits: fetch address, equal to pc_out.
REQ-008 SHALL have port imem_ack, input, 1 bit: memory read complete; imem_rdata is valid in the same cycle.
REQ-009 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port instr, output, 32 bits: registered instruction to decode.
REQ-011 SHALL have port instr_valid, output, 1 bit: one-cycle issue pulse.
REQ-012 SHALL have port exec_done, input, 1 bit: the current instruction has retired.
REQ-013 SHALL have port branch_taken, input, 1 bit: redirect request, sampled only with exec_done.
REQ-014 SHALL have port branch_target, input, 32 bits: redirect address, sampled only with exec_done.
REQ-015 SHALL have port halt, input, 1 bit: stop request, sampled only with exec_done.
REQ-016 SHALL have port pc_out, output, 32 bits: current PC.
REQ-017 SHALL have port busy, output, 1 bit: high in FETCH, ISSUE and WAIT_EXEC.
REQ-018 SHALL have port misalign_err, output, 1 bit: sticky error flag for a misaligned branch target.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT_EXEC and HALT.
REQ-020 In IDLE or HALT, start=1 SHALL load pc_out=RESET_VECTOR, clear misalign_err and enter FETCH on the next edge; start SHALL be ignored in every other state.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL hold pc_out stable until imem_ack=1; imem_req SHALL be 0 in all other states.
REQ-022 imem_ack=1 in FETCH SHALL register imem_rdata into instr and enter ISSUE; imem_ack outside FETCH SHALL be ignored.
REQ-023 ISSUE SHALL last exactly one cycle with instr_valid=1, then enter WAIT_EXEC; instr SHALL hold its value until the next ack.
REQ-024 In WAIT_EXEC, exec_done=1 SHALL select the next action in this order: halt=1 → HALT with pc_out unchanged; branch_taken=1 with branch_target[1:0]≠0 → misalign_err=1, HALT, pc_out unchanged; branch_taken=1 → pc_out=branch_target, FETCH; otherwise pc_out=pc_out+PC_STEP, FETCH.
REQ-025 The PC add SHALL be a 32-bit modulo operation: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
REQ-026 exec_done SHALL be ignored outside WAIT_EXEC.
REQ-027 Latency: start at edge N → imem_req=1 after N; ack at edge M → instr_valid=1 for the cycle after M; exec_done at edge K → new pc_out and imem_req=1 after K.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, pc_out=RESET_VECTOR, instr=0, instr_valid=0, imem_req=0, busy=0 and misalign_err=0, including mid-fetch.
REQ-029 After reset deassertion, the block SHALL remain in IDLE until start=1.

Structure
REQ-030 The state encoding typedef, the PC_STEP default and the RESET_VECTOR default SHALL live in the shared CPU package.
REQ-031 The PC register with load enable SHALL be one sub-module, pc_reg; the FSM and next-PC mux SHALL be in fetch_sequencer.

Verification
REQ-032 Reset, then start: imem_addr=0 and imem_req=1; ack with rdata=32'hDEADBEEF after 3 wait cycles → instr=32'hDEADBEEF with a single instr_valid pulse.
REQ-033 Sequential flow: three exec_done with branch_taken=0 → pc_out steps 0→4→8→12.
REQ-034 Branch: exec_done with branch_taken=1 and target=32'h100 → next imem_addr=32'h100; with target=32'h102 → misalign_err=1, state HALT, pc_out unchanged.
REQ-035 Wrap and halt: pc_out=32'hFFFF_FFFC with exec_done → pc_out=0; exec_done with halt=1 and branch_taken=1 → HALT, pc_out unchanged, busy=0; then start → pc_out=RESET_VECTOR and misalign_err=0.
REQ-036 Reset asserted while FETCH is waiting for ack → immediate IDLE with imem_req=0; a late ack is ignored.
REQ-037 A spurious exec_done in FETCH and a spurious start in WAIT_EXEC → no change in state or pc_out.
